axil_reg_bridge: RTL and testbench

AXI4-Lite slave that connects the PS master port (HPM0 FPD) to the TLK2711 register bus. It turns AXI write and read transactions into single-cycle register write and read strobes. Read data comes back from the register block at a fixed latency after the read strobe and is returned on the R channel. Write and read paths are independent, so one of each can be in flight at the same time.

---
 rtl/axil_reg_bridge.sv | 170 +++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave turning AXI writes/reads into single-cycle register bus strobes.
// Ports: clk/rst_n (sync, active-low); AXI4-Lite AW/W/B and AR/R channels (64-bit data);
//        register bus o_reg_wen/o_reg_waddr/o_reg_wdata, o_reg_ren/o_reg_raddr, i_reg_rdata
//        (i_reg_rdata valid RD_LATENCY cycles after o_reg_ren).
module axil_reg_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [63:0]               s_axi_wdata,
  input  logic [7:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [63:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      o_reg_wen,
  output logic [15:0]               o_reg_waddr,
  output logic [63:0]               o_reg_wdata,
  output logic                      o_reg_ren,
  output logic [15:0]               o_reg_raddr,
  input  logic [63:0]               i_reg_rdata
);
  localparam logic [1:0] W_IDLE = 2'd0, W_ISSUE = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_ISSUE = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3;
  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);
  localparam logic [1:0] SLVERR = 2'b10;
  logic [1:0]  w_state, r_state, r_cnt;
  logic        aw_held, w_held, r_err;
  logic [15:0] awaddr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  // Upper address bits are decoded upstream.
  logic        unused_addr;
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};
  // Merge a handshake in the current cycle with what is already held, so the
  // strobe can issue the cycle after whichever of AW/W arrives last.
  logic        aw_hs, w_hs, aw_n, w_n, w_err;
  logic [15:0] waddr_n;
  logic [63:0] wdata_n;
  logic [7:0]  wstrb_n;
  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign aw_n    = aw_held || aw_hs;
  assign w_n     = w_held || w_hs;
  assign waddr_n = aw_hs ? s_axi_awaddr[15:0] : awaddr_q;
  assign wdata_n = w_hs ? s_axi_wdata : wdata_q;
  assign wstrb_n = w_hs ? s_axi_wstrb : wstrb_q;
  assign w_err   = (waddr_n[2:0] != 3'd0) || (wstrb_n != 8'hFF);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      o_reg_wen     <= 1'b0;
      o_reg_waddr   <= '0;
      o_reg_wdata   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) awaddr_q <= s_axi_awaddr[15:0];
          if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
          end
          if (aw_n && w_n) begin
            w_state       <= W_ISSUE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            o_reg_wen     <= !w_err;
            s_axi_bresp   <= w_err ? SLVERR : 2'b00;
            if (!w_err) begin
              o_reg_waddr <= waddr_n;
              o_reg_wdata <= wdata_n;
            end
          end else begin
            aw_held       <= aw_n;
            w_held        <= w_n;
            s_axi_awready <= !aw_n;
            s_axi_wready  <= !w_n;
          end
        end
        W_ISSUE: begin
          o_reg_wen    <= 1'b0;
          s_axi_bvalid <= 1'b1;
          w_state      <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      r_cnt         <= '0;
      r_err         <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      o_reg_ren     <= 1'b0;
      o_reg_raddr   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            r_state       <= R_ISSUE;
            r_err         <= s_axi_araddr[2:0] != 3'd0;
            o_reg_ren     <= s_axi_araddr[2:0] == 3'd0;
            if (s_axi_araddr[2:0] == 3'd0) o_reg_raddr <= s_axi_araddr[15:0];
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_ISSUE: begin
          o_reg_ren <= 1'b0;
          r_cnt     <= LAT_M1;
          r_state   <= R_WAIT;
        end
        R_WAIT: begin
          if (r_cnt == 2'd0) begin
            s_axi_rdata  <= r_err ? 64'd0 : i_reg_rdata;
            s_axi_rresp  <= r_err ? SLVERR : 2'b00;
            s_axi_rvalid <= 1'b1;
            r_state      <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb_axil_reg_bridge: self-checking bench for axil_reg_bridge with a register-block stand-in and a behavioural register model.
module tb_axil_reg_bridge;
  localparam int AW = 32;
  localparam int L  = 1;
  logic          clk = 0, rst_n = 0;
  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic          s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
  logic [63:0]   s_axi_wdata = '0;
  logic [7:0]    s_axi_wstrb = '0;
  logic          s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic [63:0]   s_axi_rdata, o_reg_wdata, i_reg_rdata;
  logic          o_reg_wen, o_reg_ren;
  logic [15:0]   o_reg_waddr, o_reg_raddr;
  always #5 clk = ~clk;
  axil_reg_bridge #(.AXI_ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
    .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
  );
  // Register block stand-in: data valid exactly L=1 cycle after o_reg_ren, junk otherwise.
  logic [63:0] mem [int];
  logic [63:0] rd_pipe = 64'hBAD0_BAD0_BAD0_BAD0;
  assign i_reg_rdata = rd_pipe;
  always @(posedge clk) begin
    rd_pipe <= o_reg_ren ? (mem.exists(int'(o_reg_raddr[15:3])) ? mem[int'(o_reg_raddr[15:3])] : 64'h0) : 64'hBAD0_BAD0_BAD0_BAD0;
    if (o_reg_wen) mem[int'(o_reg_waddr[15:3])] = o_reg_wdata;
  end
  // Bus monitor.
  int cyc = 0, wen_cnt = 0, wen_cyc = -1, ren_cnt = 0, ren_cyc = -1, b_cnt = 0;
  logic [15:0] wen_addr = '0, ren_addr = '0;
  logic [63:0] wen_data = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_reg_wen) begin wen_cnt <= wen_cnt + 1; wen_cyc <= cyc; wen_addr <= o_reg_waddr; wen_data <= o_reg_wdata; end
    if (o_reg_ren) begin ren_cnt <= ren_cnt + 1; ren_cyc <= cyc; ren_addr <= o_reg_raddr; end
    if (s_axi_bvalid && s_axi_bready) b_cnt <= b_cnt + 1;
  end
  // Behavioural model: register contents as seen through accepted (aligned, full-strobe) writes.
  logic [63:0] model [int];
  int tests = 0, fails = 0;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic axi_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s, input int lead,
                           output logic [1:0] resp, output int t, output int bcyc, output bit ok, output bit stall_ok);
    bit ad, wd, ha, hw;
    int n;
    ad = 0; wd = 0; n = 0; stall_ok = 1; t = -1;
    s_axi_awaddr = {16'($urandom), a}; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(ad && wd) && n < 60) begin
      s_axi_awvalid = !ad && n >= lead; s_axi_wvalid = !wd;
      ha = s_axi_awvalid && s_axi_awready; hw = s_axi_wvalid && s_axi_wready;
      if (wd && s_axi_wready) stall_ok = 0;
      if (ha || hw) t = cyc;
      @(negedge clk); n++; ad |= ha; wd |= hw;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0; ok = ad && wd;
    s_axi_bready = 1; n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
    bcyc = cyc; resp = s_axi_bresp; ok &= s_axi_bvalid;
    @(negedge clk); s_axi_bready = 0;
  endtask
  task automatic axi_read(input logic [15:0] a, input int hold, output logic [63:0] d, output logic [1:0] resp,
                          output int t, output int rcyc, output bit ok, output bit stable_ok);
    int n;
    n = 0; stable_ok = 1;
    s_axi_araddr = {16'($urandom), a}; s_axi_arvalid = 1;
    while (!s_axi_arready && n < 60) begin @(negedge clk); n++; end
    t = cyc; ok = s_axi_arready;
    @(negedge clk); s_axi_arvalid = 0; n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    rcyc = cyc; d = s_axi_rdata; resp = s_axi_rresp; ok &= s_axi_rvalid;
    repeat (hold) begin
      if (s_axi_rdata !== d || s_axi_rresp !== resp || s_axi_arready !== 1'b0 || s_axi_rvalid !== 1'b1) stable_ok = 0;
      @(negedge clk);
    end
    s_axi_rready = 1; @(negedge clk); s_axi_rready = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    tests++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin fails++; $display("FAIL reset_ready: got %b exp 000", {s_axi_awready, s_axi_wready, s_axi_arready}); end
    tests++; if ({s_axi_bvalid, s_axi_rvalid, o_reg_wen, o_reg_ren} !== 4'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0000", {s_axi_bvalid, s_axi_rvalid, o_reg_wen, o_reg_ren}); end
    tests++; if ({s_axi_bresp, s_axi_rresp, s_axi_rdata, o_reg_waddr, o_reg_wdata, o_reg_raddr} !== '0) begin fails++; $display("FAIL reset_data: got nonzero rdata=%h waddr=%h wdata=%h raddr=%h exp 0", s_axi_rdata, o_reg_waddr, o_reg_wdata, o_reg_raddr); end
    rst_n = 1;
    @(negedge clk);
    tests++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin fails++; $display("FAIL reset_release_ready: got %b exp 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
  endtask
  task automatic test_write_same_cycle();
    logic [1:0] resp; int t, bc, w0, b0; bit ok, st;
    w0 = wen_cnt; b0 = b_cnt;
    axi_write(16'h0108, 64'h0000_0000_8000_0000, 8'hFF, 0, resp, t, bc, ok, st);
    model[16'h0108 >> 3] = 64'h0000_0000_8000_0000;
    tests++; if (!ok) begin fails++; $display("FAIL wr_same_handshake: got timeout exp complete"); end
    tests++; if (wen_cnt - w0 !== 1) begin fails++; $display("FAIL wr_same_wen_count: got %0d exp 1", wen_cnt - w0); end
    tests++; if (wen_cyc !== t + 1) begin fails++; $display("FAIL wr_same_wen_cycle: got %0d exp %0d", wen_cyc, t + 1); end
    tests++; if (wen_addr !== 16'h0108) begin fails++; $display("FAIL wr_same_addr: got %h exp 0108", wen_addr); end
    tests++; if (wen_data !== 64'h0000_0000_8000_0000) begin fails++; $display("FAIL wr_same_data: got %h exp 0000000080000000", wen_data); end
    tests++; if (bc !== t + 2) begin fails++; $display("FAIL wr_same_bvalid_cycle: got %0d exp %0d", bc, t + 2); end
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL wr_same_bresp: got %b exp 00", resp); end
    tests++; if (b_cnt - b0 !== 1) begin fails++; $display("FAIL wr_same_b_count: got %0d exp 1", b_cnt - b0); end
  endtask
  task automatic test_write_w_first();
    logic [1:0] resp; logic [63:0] d; int t, bc, w0, b0; bit ok, st;
    w0 = wen_cnt; b0 = b_cnt; d = {$urandom, $urandom};
    axi_write(16'h0120, d, 8'hFF, 3, resp, t, bc, ok, st);
    model[16'h0120 >> 3] = d;
    repeat (3) @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL wr_wfirst_handshake: got timeout exp complete"); end
    tests++; if (!st) begin fails++; $display("FAIL wr_wfirst_wready: got wready=1 after W accepted exp 0"); end
    tests++; if (wen_cnt - w0 !== 1) begin fails++; $display("FAIL wr_wfirst_wen_count: got %0d exp 1", wen_cnt - w0); end
    tests++; if (wen_cyc !== t + 1) begin fails++; $display("FAIL wr_wfirst_wen_cycle: got %0d exp %0d", wen_cyc, t + 1); end
    tests++; if (wen_addr !== 16'h0120 || wen_data !== d) begin fails++; $display("FAIL wr_wfirst_addr_data: got %h/%h exp 0120/%h", wen_addr, wen_data, d); end
    tests++; if (b_cnt - b0 !== 1) begin fails++; $display("FAIL wr_wfirst_b_count: got %0d exp 1", b_cnt - b0); end
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL wr_wfirst_bresp: got %b exp 00", resp); end
  endtask
  task automatic test_write_errors();
    logic [1:0] resp; int t, bc, w0; bit ok, st;
    w0 = wen_cnt;
    axi_write(16'h0104, {$urandom, $urandom}, 8'hFF, 0, resp, t, bc, ok, st);
    tests++; if (!ok || resp !== 2'b10) begin fails++; $display("FAIL wr_misaligned_bresp: got %b ok=%0d exp 10", resp, ok); end
    tests++; if (bc !== t + 2) begin fails++; $display("FAIL wr_misaligned_timing: got %0d exp %0d", bc, t + 2); end
    axi_write(16'h0110, {$urandom, $urandom}, 8'h0F, 0, resp, t, bc, ok, st);
    tests++; if (!ok || resp !== 2'b10) begin fails++; $display("FAIL wr_partial_strb_bresp: got %b ok=%0d exp 10", resp, ok); end
    tests++; if (wen_cnt - w0 !== 0) begin fails++; $display("FAIL wr_error_no_wen: got %0d exp 0", wen_cnt - w0); end
  endtask
  task automatic test_read_backpressure();
    logic [1:0] resp; logic [63:0] d; int t, rc, bc, r0; bit ok, st;
    axi_write(16'h0200, 64'h0003_0010_0000_1234, 8'hFF, 0, resp, t, bc, ok, st);
    model[16'h0200 >> 3] = 64'h0003_0010_0000_1234;
    r0 = ren_cnt;
    axi_read(16'h0200, 5, d, resp, t, rc, ok, st);
    tests++; if (!ok) begin fails++; $display("FAIL rd_handshake: got timeout exp complete"); end
    tests++; if (ren_cnt - r0 !== 1 || ren_cyc !== t + 1) begin fails++; $display("FAIL rd_ren_cycle: got cnt=%0d cyc=%0d exp 1/%0d", ren_cnt - r0, ren_cyc, t + 1); end
    tests++; if (ren_addr !== 16'h0200) begin fails++; $display("FAIL rd_raddr: got %h exp 0200", ren_addr); end
    tests++; if (rc !== t + 2 + L) begin fails++; $display("FAIL rd_rvalid_cycle: got %0d exp %0d", rc, t + 2 + L); end
    tests++; if (d !== 64'h0003_0010_0000_1234) begin fails++; $display("FAIL rd_rdata: got %h exp 0003001000001234", d); end
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL rd_rresp: got %b exp 00", resp); end
    tests++; if (!st) begin fails++; $display("FAIL rd_backpressure_stable: got change during rready=0 exp stable, arready=0"); end
    r0 = ren_cnt;
    axi_read(16'h0204, 0, d, resp, t, rc, ok, st);
    tests++; if (!ok || resp !== 2'b10 || d !== 64'h0) begin fails++; $display("FAIL rd_misaligned: got resp=%b data=%h exp 10/0", resp, d); end
    tests++; if (ren_cnt - r0 !== 0) begin fails++; $display("FAIL rd_misaligned_no_ren: got %0d exp 0", ren_cnt - r0); end
    tests++; if (rc !== t + 2 + L) begin fails++; $display("FAIL rd_misaligned_timing: got %0d exp %0d", rc, t + 2 + L); end
  endtask
  task automatic test_simultaneous();
    logic [1:0] bresp, rresp; logic [63:0] wd, rd, exp; int tw, tr, bc, rc; bit okw, okr, st1, st2;
    wd = {$urandom, $urandom};
    exp = model.exists(16'h0300 >> 3) ? model[16'h0300 >> 3] : 64'h0;
    fork
      axi_write(16'h0100, wd, 8'hFF, 0, bresp, tw, bc, okw, st1);
      axi_read(16'h0300, 0, rd, rresp, tr, rc, okr, st2);
    join
    model[16'h0100 >> 3] = wd;
    tests++; if (!okw || !okr || tw !== tr) begin fails++; $display("FAIL sim_handshake: got okw=%0d okr=%0d tw=%0d tr=%0d exp same cycle", okw, okr, tw, tr); end
    tests++; if (wen_cyc !== tw + 1 || ren_cyc !== tr + 1) begin fails++; $display("FAIL sim_strobes: got wen=%0d ren=%0d exp %0d", wen_cyc, ren_cyc, tw + 1); end
    tests++; if (bresp !== 2'b00 || rresp !== 2'b00 || rd !== exp) begin fails++; $display("FAIL sim_responses: got %b/%b/%h exp 00/00/%h", bresp, rresp, rd, exp); end
  endtask
  task automatic test_reset_mid();
    bit seen;
    s_axi_araddr = 32'h0000_0208; s_axi_arvalid = 1;
    @(negedge clk);
    s_axi_arvalid = 0;
    s_axi_awaddr = 32'h0000_0210; s_axi_wdata = {$urandom, $urandom}; s_axi_wstrb = 8'hFF;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 1; s_axi_rready = 1;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0; rst_n = 0;
    @(negedge clk);
    tests++; if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin fails++; $display("FAIL mid_reset_outputs: got %b exp 00000", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}); end
    rst_n = 1;
    @(negedge clk);
    tests++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin fails++; $display("FAIL mid_reset_release_ready: got %b exp 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
    seen = 0;
    repeat (8) begin seen |= s_axi_bvalid || s_axi_rvalid; @(negedge clk); end
    s_axi_bready = 0; s_axi_rready = 0;
    tests++; if (seen) begin fails++; $display("FAIL mid_reset_no_response: got bvalid/rvalid=1 exp never"); end
  endtask
  task automatic test_random();
    logic [1:0] resp; logic [15:0] a; logic [7:0] s; logic [63:0] d, exp; int t, c, c0; bit ok, st, err;
    for (int i = 0; i < 40; i++) begin
      a = {8'h00, 5'($urandom), ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b000};
      if ($urandom_range(0, 1) == 0) begin
        s = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
        d = {$urandom, $urandom};
        err = a[2:0] != 0 || s != 8'hFF;
        c0 = wen_cnt;
        axi_write(a, d, s, $urandom_range(0, 2), resp, t, c, ok, st);
        if (!err) model[int'(a >> 3)] = d;
        tests++; if (!ok || resp !== (err ? 2'b10 : 2'b00) || wen_cnt - c0 !== (err ? 0 : 1)) begin fails++; $display("FAIL rand_write a=%h s=%h: got resp=%b wens=%0d ok=%0d exp resp=%b wens=%0d", a, s, resp, wen_cnt - c0, ok, err ? 2'b10 : 2'b00, err ? 0 : 1); end
      end else begin
        err = a[2:0] != 0;
        exp = err ? 64'h0 : (model.exists(int'(a >> 3)) ? model[int'(a >> 3)] : 64'h0);
        c0 = ren_cnt;
        axi_read(a, $urandom_range(0, 3), d, resp, t, c, ok, st);
        tests++; if (!ok || !st || d !== exp || resp !== (err ? 2'b10 : 2'b00) || c !== t + 2 + L || ren_cnt - c0 !== (err ? 0 : 1)) begin fails++; $display("FAIL rand_read a=%h: got data=%h resp=%b lat=%0d rens=%0d stable=%0d exp data=%h lat=%0d", a, d, resp, c - t, ren_cnt - c0, st, exp, 2 + L); end
      end
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_write_same_cycle();
    test_write_w_first();
    test_write_errors();
    test_read_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
